// File: rtl/class_lu_initiator.sv
// class_lu_initiator
//   Requester side of the classifier main-path lookup interface. A key accepted
//   from the packet pipeline is sent to the classifier as three bus beats.
//   lu_vld marks beat 0 only, and a new key can start at most every 4 cycles.
//   The caller's tag is queued for each accepted key. The in-order lu_done
//   results are then returned on rsp_* with the tag of the oldest outstanding
//   request.
//
//   Optional feature: define CLASS_LU_TIMEOUT_EN to build the outstanding-lookup
//   watchdog (err_timeout, req_rdy blocked until reset). Without it err_timeout
//   is tied to 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_vld/req_rdy       key request handshake; req_key, req_tag captured on accept
//   lu_vld, lu_key        classifier bus: strobe on beat 0, beat data
//   lu_done, lu_err,
//   lu_hit_miss, lu_vid   in-order classifier result
//   rsp_vld, rsp_tag,
//   rsp_err, rsp_hit_miss,
//   rsp_vid               tagged result, one cycle after lu_done
//   outstanding           accepted minus completed lookups
//   err_spurious          sticky: lu_done seen with nothing outstanding
//   err_timeout           sticky watchdog flag
module class_lu_initiator #(
  parameter int KEY_LEN         = 276,
  parameter int BUS_WIDTH       = 128,
  parameter int VID_WIDTH       = 15,
  parameter int TAG_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   req_vld,
  output logic                                   req_rdy,
  input  logic [KEY_LEN-1:0]                     req_key,
  input  logic [TAG_WIDTH-1:0]                   req_tag,
  output logic                                   lu_vld,
  output logic [BUS_WIDTH-1:0]                   lu_key,
  input  logic                                   lu_done,
  input  logic                                   lu_err,
  input  logic                                   lu_hit_miss,
  input  logic [VID_WIDTH-1:0]                   lu_vid,
  output logic                                   rsp_vld,
  output logic [TAG_WIDTH-1:0]                   rsp_tag,
  output logic                                   rsp_err,
  output logic                                   rsp_hit_miss,
  output logic [VID_WIDTH-1:0]                   rsp_vid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_spurious,
  output logic                                   err_timeout
);

  localparam int T    = KEY_LEN - 2*BUS_WIDTH;
  localparam int RK_W = KEY_LEN - BUS_WIDTH;
  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int CW   = $clog2(MAX_OUTSTANDING+1);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, GAP} state_t;

  state_t                 state, state_nxt;
  logic                   accept, done_ok, to_nxt;
  logic                   lu_vld_nxt, req_rdy_nxt;
  logic [BUS_WIDTH-1:0]   lu_key_nxt;
  logic [CW-1:0]          cnt_nxt;

  // Beat 0 goes straight out of req_key, so only the lower part is held.
  logic [RK_W-1:0]        key_p0;
  logic [TAG_WIDTH-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]          wr_ptr, rd_ptr;

  assign accept  = req_vld & req_rdy;
  // A result with nothing outstanding is dropped: no pop, no response.
  assign done_ok = lu_done & (outstanding != '0);

  always_comb begin
    cnt_nxt = outstanding;
    if (accept && !done_ok)
      cnt_nxt = outstanding + CW'(1);
    else if (!accept && done_ok)
      cnt_nxt = outstanding - CW'(1);
  end

  // ---- Stage boundary: FSM state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are registered, so the beat for the state being entered is
  // computed here and loaded alongside the state.
  always_comb begin
    state_nxt  = state;
    lu_vld_nxt = 1'b0;
    lu_key_nxt = '0;
    case (state)
      IDLE, GAP: begin
        if (accept) begin
          state_nxt  = B0;
          lu_vld_nxt = 1'b1;
          lu_key_nxt = req_key[KEY_LEN-1 -: BUS_WIDTH];
        end else begin
          state_nxt  = IDLE;
        end
      end
      B0: begin
        state_nxt  = B1;
        lu_key_nxt = key_p0[RK_W-1 -: BUS_WIDTH];
      end
      B1: begin
        state_nxt  = B2;
        lu_key_nxt[BUS_WIDTH-1 -: T] = key_p0[T-1:0];
      end
      B2:      state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  assign req_rdy_nxt = ((state_nxt == IDLE) || (state_nxt == GAP)) &&
                       (cnt_nxt < CW'(MAX_OUTSTANDING)) && !to_nxt;

`ifdef CLASS_LU_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] wd_cnt, wd_nxt;

  always_comb begin
    wd_nxt = wd_cnt;
    if ((accept && (outstanding == '0)) || lu_done)
      wd_nxt = '0;
    else if ((outstanding != '0) && (wd_cnt != WD_W'(TIMEOUT_CYCLES)))
      wd_nxt = wd_cnt + WD_W'(1);
  end

  assign to_nxt = err_timeout | (wd_nxt == WD_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) wd_cnt <= '0;
    else        wd_cnt <= wd_nxt;
  end
`else
  // Watchdog compiled out; the term keeps TIMEOUT_CYCLES referenced.
  assign to_nxt = (TIMEOUT_CYCLES < 1) & 1'b0;
`endif

  // ---- Stage boundary: key capture and tag storage (data, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      key_p0          <= req_key[RK_W-1:0];
      tag_mem[wr_ptr] <= req_tag;
    end
  end

  // ---- Stage boundary: control and output registers ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      outstanding  <= '0;
      req_rdy      <= 1'b0;
      lu_vld       <= 1'b0;
      lu_key       <= '0;
      rsp_vld      <= 1'b0;
      rsp_tag      <= '0;
      rsp_err      <= 1'b0;
      rsp_hit_miss <= 1'b0;
      rsp_vid      <= '0;
      err_spurious <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (accept)  wr_ptr <= wr_ptr + PW'(1);
      if (done_ok) rd_ptr <= rd_ptr + PW'(1);
      outstanding  <= cnt_nxt;
      req_rdy      <= req_rdy_nxt;
      lu_vld       <= lu_vld_nxt;
      lu_key       <= lu_key_nxt;
      rsp_vld      <= done_ok;
      if (done_ok) begin
        rsp_tag      <= tag_mem[rd_ptr];
        rsp_err      <= lu_err;
        rsp_hit_miss <= lu_hit_miss;
        rsp_vid      <= lu_vid;
      end
      err_spurious <= err_spurious | (lu_done & (outstanding == '0));
      err_timeout  <= to_nxt;
    end
  end

endmodule

// File: tb/tb_class_lu_initiator.sv
module tb_class_lu_initiator;

  localparam int KL   = 276;
  localparam int BW   = 128;
  localparam int VW   = 15;
  localparam int TW   = 8;
  localparam int MAXO = 16;
  localparam int T    = KL - 2*BW;
  localparam int CW   = $clog2(MAXO+1);
`ifdef CLASS_LU_TIMEOUT_EN
  localparam int TO   = 64;
`else
  localparam int TO   = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic [KL-1:0] req_key = '0;
  logic [TW-1:0] req_tag = '0;
  logic          lu_vld;
  logic [BW-1:0] lu_key;
  logic          lu_done = 1'b0;
  logic          lu_err = 1'b0;
  logic          lu_hit_miss = 1'b0;
  logic [VW-1:0] lu_vid = '0;
  logic          rsp_vld;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;
  logic          rsp_hit_miss;
  logic [VW-1:0] rsp_vid;
  logic [CW-1:0] outstanding;
  logic          err_spurious;
  logic          err_timeout;

  class_lu_initiator #(
    .KEY_LEN(KL), .BUS_WIDTH(BW), .VID_WIDTH(VW), .TAG_WIDTH(TW),
    .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_key(req_key), .req_tag(req_tag),
    .lu_vld(lu_vld), .lu_key(lu_key),
    .lu_done(lu_done), .lu_err(lu_err), .lu_hit_miss(lu_hit_miss), .lu_vid(lu_vid),
    .rsp_vld(rsp_vld), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .rsp_hit_miss(rsp_hit_miss), .rsp_vid(rsp_vid),
    .outstanding(outstanding), .err_spurious(err_spurious), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase = edges since the last accepted key (99 = idle),
  // a queue of pending tags and a count of lookups in flight.
  int            m_phase = 99;
  int            m_cnt = 0;
  int            m_wd = 0;
  bit            m_to = 1'b0;
  logic [TW-1:0] m_q[$];
  logic [KL-1:0] m_key = '0;
  bit            m_acc = 1'b0;
  logic          e_rdy = 1'b0, e_vld = 1'b0, e_spur = 1'b0, e_rsp_vld = 1'b0;
  logic [BW-1:0] e_key = '0;
  logic [TW-1:0] e_rsp_tag = '0;
  logic          e_rsp_err = 1'b0, e_rsp_hit = 1'b0;
  logic [VW-1:0] e_rsp_vid = '0;

  function automatic logic [KL-1:0] rand_key();
    logic [287:0] tmp;
    for (int i = 0; i < 9; i++) tmp[i*32 +: 32] = $urandom;
    return tmp[KL-1:0];
  endfunction

  // One clock edge: advances the model from the inputs presented before the
  // edge, then leaves the bench 1 time unit after the edge.
  task automatic tick();
    logic acc, dn;
    logic [BW-1:0] tl;
    acc = req_vld && e_rdy && rst_n;
    dn  = lu_done && (m_cnt > 0);
    @(posedge clk);
    m_acc = 1'b0;
    if (!rst_n) begin
      m_phase = 99; m_cnt = 0; m_q.delete(); m_wd = 0; m_to = 1'b0;
      e_rdy = 1'b0; e_spur = 1'b0; e_rsp_vld = 1'b0;
      e_rsp_tag = '0; e_rsp_err = 1'b0; e_rsp_hit = 1'b0; e_rsp_vid = '0;
    end else begin
      e_rsp_vld = dn;
      if (lu_done && m_cnt == 0) e_spur = 1'b1;
      if (dn) begin
        e_rsp_tag = m_q.pop_front();
        e_rsp_err = lu_err; e_rsp_hit = lu_hit_miss; e_rsp_vid = lu_vid;
      end
`ifdef CLASS_LU_TIMEOUT_EN
      if ((acc && m_cnt == 0) || lu_done) m_wd = 0;
      else if (m_cnt > 0 && m_wd < TO) m_wd++;
      if (m_wd == TO) m_to = 1'b1;
`endif
      if (acc) begin
        m_q.push_back(req_tag); m_key = req_key; m_phase = 0; m_acc = 1'b1;
      end else if (m_phase < 99) begin
        m_phase++;
      end
      m_cnt = m_cnt + int'(acc) - int'(dn);
      e_rdy = (m_phase >= 3) && (m_cnt < MAXO) && !m_to;
    end
    e_vld = (m_phase == 0);
    tl = '0;
    case (m_phase)
      0: e_key = m_key[KL-1 -: BW];
      1: e_key = m_key[KL-BW-1 -: BW];
      2: begin tl[BW-1 -: T] = m_key[T-1:0]; e_key = tl; end
      default: e_key = '0;
    endcase
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++; if (req_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_req_rdy got %b exp 0", req_rdy); end
    vectors++; if (lu_vld !== 1'b0) begin miscompares++; $display("FAIL rst_lu_vld got %b exp 0", lu_vld); end
    vectors++; if (lu_key !== '0) begin miscompares++; $display("FAIL rst_lu_key got %h exp 0", lu_key); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_vld got %b exp 0", rsp_vld); end
    vectors++; if (rsp_tag !== '0) begin miscompares++; $display("FAIL rst_rsp_tag got %h exp 0", rsp_tag); end
    vectors++; if (rsp_vid !== '0) begin miscompares++; $display("FAIL rst_rsp_vid got %h exp 0", rsp_vid); end
    vectors++; if (outstanding !== '0) begin miscompares++; $display("FAIL rst_outstanding got %0d exp 0", outstanding); end
    vectors++; if (err_spurious !== 1'b0) begin miscompares++; $display("FAIL rst_err_spurious got %b exp 0", err_spurious); end
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL rst_err_timeout got %b exp 0", err_timeout); end
    rst_n = 1'b1;
    tick();
    vectors++; if (req_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_release_rdy got %b exp 1", req_rdy); end
  endtask

  task automatic test_single_key();
    logic [KL-1:0] key;
    key = {4'h1, {8{32'h23456789}}, 16'hABCD};
    req_vld = 1'b1; req_key = key; req_tag = 8'h05;
    tick();
    req_vld = 1'b0;
    vectors++; if (lu_vld !== 1'b1) begin miscompares++; $display("FAIL single_b0_vld got %b exp 1", lu_vld); end
    vectors++; if (lu_key !== key[275:148]) begin miscompares++; $display("FAIL single_b0_key got %h exp %h", lu_key, key[275:148]); end
    tick();
    vectors++; if (lu_vld !== 1'b0) begin miscompares++; $display("FAIL single_b1_vld got %b exp 0", lu_vld); end
    vectors++; if (lu_key !== key[147:20]) begin miscompares++; $display("FAIL single_b1_key got %h exp %h", lu_key, key[147:20]); end
    tick();
    vectors++; if (lu_key !== {key[19:0], 108'b0}) begin miscompares++; $display("FAIL single_b2_key got %h exp %h", lu_key, {key[19:0], 108'b0}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (lu_vld !== e_vld || lu_key !== e_key) begin miscompares++; $display("FAIL single_idle vld/key got %b/%h exp %b/%h", lu_vld, lu_key, e_vld, e_key); end
    end
    lu_done = 1'b1; lu_hit_miss = 1'b1; lu_err = 1'b0; lu_vid = 15'h0042;
    tick();
    lu_done = 1'b0;
    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL single_rsp_vld got %b exp 1", rsp_vld); end
    vectors++; if (rsp_tag !== 8'h05) begin miscompares++; $display("FAIL single_rsp_tag got %h exp 05", rsp_tag); end
    vectors++; if (rsp_hit_miss !== 1'b1 || rsp_err !== 1'b0) begin miscompares++; $display("FAIL single_rsp_hit_err got %b/%b exp 1/0", rsp_hit_miss, rsp_err); end
    vectors++; if (rsp_vid !== 15'h0042) begin miscompares++; $display("FAIL single_rsp_vid got %h exp 0042", rsp_vid); end
    tick();
    vectors++; if (rsp_vld !== 1'b0 || outstanding !== '0) begin miscompares++; $display("FAIL single_after got vld %b cnt %0d exp 0/0", rsp_vld, outstanding); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int last = -1;
    int cyc = 0;
    req_vld = 1'b1; req_key = rand_key(); req_tag = TW'($urandom);
    while (accepts < 5 && cyc < 40) begin
      tick(); cyc++;
      if (m_acc) begin accepts++; req_key = rand_key(); req_tag = TW'($urandom); end
      if (accepts == 5) req_vld = 1'b0;
      vectors++; if (lu_vld !== e_vld || lu_key !== e_key) begin miscompares++; $display("FAIL b2b_beat cyc %0d got %b/%h exp %b/%h", cyc, lu_vld, lu_key, e_vld, e_key); end
      vectors++; if (req_rdy !== e_rdy || outstanding !== CW'(m_cnt)) begin miscompares++; $display("FAIL b2b_ctl cyc %0d rdy/cnt got %b/%0d exp %b/%0d", cyc, req_rdy, outstanding, e_rdy, m_cnt); end
      if (lu_vld === 1'b1) begin
        if (last >= 0) begin
          vectors++; if (cyc - last !== 4) begin miscompares++; $display("FAIL b2b_spacing got %0d exp 4", cyc - last); end
        end
        last = cyc;
      end
    end
    req_vld = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++; if (outstanding !== CW'(5)) begin miscompares++; $display("FAIL b2b_outstanding got %0d exp 5", outstanding); end
  endtask

  task automatic test_done_burst();
    for (int i = 0; i < 3; i++) begin
      lu_done = 1'b1; lu_err = 1'($urandom); lu_hit_miss = 1'($urandom); lu_vid = VW'($urandom);
      tick();
      vectors++; if (rsp_vld !== e_rsp_vld || rsp_tag !== e_rsp_tag) begin miscompares++; $display("FAIL burst_tag %0d got %b/%h exp %b/%h", i, rsp_vld, rsp_tag, e_rsp_vld, e_rsp_tag); end
      vectors++; if (rsp_err !== e_rsp_err || rsp_hit_miss !== e_rsp_hit || rsp_vid !== e_rsp_vid) begin miscompares++; $display("FAIL burst_fields %0d got %b/%b/%h exp %b/%b/%h", i, rsp_err, rsp_hit_miss, rsp_vid, e_rsp_err, e_rsp_hit, e_rsp_vid); end
    end
    lu_done = 1'b0;
    tick();
    vectors++; if (rsp_vld !== 1'b0 || outstanding !== CW'(2)) begin miscompares++; $display("FAIL burst_end vld/cnt got %b/%0d exp 0/2", rsp_vld, outstanding); end
    lu_done = 1'b1;
    tick(); tick();
    lu_done = 1'b0;
    vectors++; if (rsp_tag !== e_rsp_tag || outstanding !== '0) begin miscompares++; $display("FAIL burst_drain tag/cnt got %h/%0d exp %h/0", rsp_tag, outstanding, e_rsp_tag); end
  endtask

  task automatic test_full();
    int cyc = 0;
    req_vld = 1'b1;
    while (m_cnt < MAXO && cyc < 200) begin
      req_tag = TW'($urandom); req_key = rand_key();
      tick(); cyc++;
      vectors++; if (req_rdy !== e_rdy || outstanding !== CW'(m_cnt)) begin miscompares++; $display("FAIL full_fill rdy/cnt got %b/%0d exp %b/%0d", req_rdy, outstanding, e_rdy, m_cnt); end
    end
    if (m_cnt < MAXO) begin miscompares++; $display("FAIL full_fill_timeout got %0d exp %0d", m_cnt, MAXO); end
    for (int i = 0; i < 6; i++) tick();
    vectors++; if (req_rdy !== 1'b0 || outstanding !== CW'(16)) begin miscompares++; $display("FAIL full_block rdy/cnt got %b/%0d exp 0/16", req_rdy, outstanding); end
    lu_done = 1'b1;
    tick();
    vectors++; if (req_rdy !== 1'b1 || outstanding !== CW'(15)) begin miscompares++; $display("FAIL full_reopen rdy/cnt got %b/%0d exp 1/15", req_rdy, outstanding); end
    vectors++; if (rsp_tag !== e_rsp_tag) begin miscompares++; $display("FAIL full_rsp_tag got %h exp %h", rsp_tag, e_rsp_tag); end
    tick();
    lu_done = 1'b0; req_vld = 1'b0;
    vectors++; if (outstanding !== CW'(15) || lu_vld !== 1'b1) begin miscompares++; $display("FAIL full_acc_done cnt/vld got %0d/%b exp 15/1", outstanding, lu_vld); end
    lu_done = 1'b1;
    cyc = 0;
    while (m_cnt > 0 && cyc < 40) begin
      tick(); cyc++;
      vectors++; if (rsp_vld !== e_rsp_vld || rsp_tag !== e_rsp_tag) begin miscompares++; $display("FAIL full_drain got %b/%h exp %b/%h", rsp_vld, rsp_tag, e_rsp_vld, e_rsp_tag); end
    end
    lu_done = 1'b0;
    tick();
  endtask

  task automatic test_spurious_and_reset();
    lu_done = 1'b1;
    tick();
    lu_done = 1'b0;
    vectors++; if (err_spurious !== 1'b1) begin miscompares++; $display("FAIL spur_flag got %b exp 1", err_spurious); end
    vectors++; if (rsp_vld !== 1'b0 || outstanding !== '0) begin miscompares++; $display("FAIL spur_side vld/cnt got %b/%0d exp 0/0", rsp_vld, outstanding); end
    tick(); tick(); tick();
    req_vld = 1'b1; req_key = rand_key(); req_tag = TW'($urandom);
    tick();
    req_vld = 1'b0;
    tick();
    vectors++; if (lu_key !== e_key || m_phase != 1) begin miscompares++; $display("FAIL rstmid_b1 got %h exp %h", lu_key, e_key); end
    rst_n = 1'b0;
    tick();
    vectors++; if (lu_vld !== 1'b0 || lu_key !== '0) begin miscompares++; $display("FAIL rstmid_abort got %b/%h exp 0/0", lu_vld, lu_key); end
    vectors++; if (err_spurious !== 1'b0 || outstanding !== '0) begin miscompares++; $display("FAIL rstmid_clear got %b/%0d exp 0/0", err_spurious, outstanding); end
    rst_n = 1'b1;
    tick();
    vectors++; if (lu_key !== '0 || lu_vld !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got %b/%h exp 0/0", lu_vld, lu_key); end
    lu_done = 1'b1;
    tick();
    lu_done = 1'b0;
    vectors++; if (err_spurious !== 1'b1 || rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rstmid_late got spur %b vld %b exp 1/0", err_spurious, rsp_vld); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_vld = 1'($urandom); req_key = rand_key(); req_tag = TW'($urandom);
      lu_done = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
      lu_err = 1'($urandom); lu_hit_miss = 1'($urandom); lu_vid = VW'($urandom);
      tick();
      vectors++; if (lu_vld !== e_vld || lu_key !== e_key) begin miscompares++; $display("FAIL rnd_beat %0d got %b/%h exp %b/%h", i, lu_vld, lu_key, e_vld, e_key); end
      vectors++; if (req_rdy !== e_rdy || outstanding !== CW'(m_cnt) || err_spurious !== e_spur) begin miscompares++; $display("FAIL rnd_ctl %0d rdy/cnt/spur got %b/%0d/%b exp %b/%0d/%b", i, req_rdy, outstanding, err_spurious, e_rdy, m_cnt, e_spur); end
      vectors++; if (rsp_vld !== e_rsp_vld) begin miscompares++; $display("FAIL rnd_rsp_vld %0d got %b exp %b", i, rsp_vld, e_rsp_vld); end
      if (e_rsp_vld) begin
        vectors++; if (rsp_tag !== e_rsp_tag || rsp_err !== e_rsp_err || rsp_hit_miss !== e_rsp_hit || rsp_vid !== e_rsp_vid) begin miscompares++; $display("FAIL rnd_rsp %0d got %h/%b/%b/%h exp %h/%b/%b/%h", i, rsp_tag, rsp_err, rsp_hit_miss, rsp_vid, e_rsp_tag, e_rsp_err, e_rsp_hit, e_rsp_vid); end
      end
    end
    req_vld = 1'b0; lu_done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
`ifdef CLASS_LU_TIMEOUT_EN
    logic [TW-1:0] tag;
    int cyc = 0;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    tag = TW'($urandom);
    req_vld = 1'b1; req_key = rand_key(); req_tag = tag;
    tick();
    req_vld = 1'b0;
    while (!m_to && cyc < 200) begin
      tick(); cyc++;
      vectors++; if (err_timeout !== m_to || req_rdy !== e_rdy) begin miscompares++; $display("FAIL to_track to/rdy got %b/%b exp %b/%b", err_timeout, req_rdy, m_to, e_rdy); end
    end
    tick();
    vectors++; if (err_timeout !== 1'b1 || req_rdy !== 1'b0) begin miscompares++; $display("FAIL to_flag to/rdy got %b/%b exp 1/0", err_timeout, req_rdy); end
    lu_done = 1'b1;
    tick();
    lu_done = 1'b0;
    vectors++; if (rsp_vld !== 1'b1 || rsp_tag !== tag) begin miscompares++; $display("FAIL to_late_rsp got %b/%h exp 1/%h", rsp_vld, rsp_tag, tag); end
`else
    vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL to_tied got %b exp 0", err_timeout); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_back_to_back();
    test_done_burst();
    test_full();
    test_spurious_and_reset();
    test_random();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
